// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM word address and
// captures the ROM's same-cycle instruction word into the IF/ID register.
module instr_fetch_stage #(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         flush,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_target,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    output logic [N-1:0] if_id_instr,
    output logic [N-1:0] if_id_pc,
    output logic [N-1:0] if_id_pc_plus1,
    output logic         if_id_valid,
    output logic         halted,
    output logic [N-1:0] fetch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [N-1:0] LIMIT = N'(DEPTH);

    state_t       state, state_next;
    logic [N-1:0] pc, pc_next;
    logic [N-1:0] pc_inc;
    logic [N-1:0] instr_next, ipc_next, ipc1_next, count_next;
    logic         valid_next;

    // ROM address comes straight from the PC register
    assign imem_addr = pc;
    assign pc_inc    = pc + N'(1);

    // State, PC and IF/ID register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            halted         <= 1'b0;
            pc             <= '0;
            if_id_instr    <= '0;
            if_id_pc       <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            state          <= state_next;
            halted         <= (state_next == HALT);
            pc             <= pc_next;
            if_id_instr    <= instr_next;
            if_id_pc       <= ipc_next;
            if_id_pc_plus1 <= ipc1_next;
            if_id_valid    <= valid_next;
            fetch_count    <= count_next;
        end
    end

    // Next-state and datapath selection, in priority order
    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = if_id_instr;
        ipc_next   = if_id_pc;
        ipc1_next  = if_id_pc_plus1;
        valid_next = if_id_valid;
        count_next = fetch_count;

        if (redirect_valid) begin
            pc_next    = redirect_target;
            instr_next = '0;
            ipc_next   = '0;
            ipc1_next  = '0;
            valid_next = 1'b0;
            state_next = (redirect_target >= LIMIT) ? HALT : RUN;
        end else if (state == HALT) begin
            instr_next = '0;
            ipc_next   = '0;
            ipc1_next  = '0;
            valid_next = 1'b0;
        end else if (pc >= LIMIT) begin
            // Out-of-range PC: never sample the ROM, park in HALT
            instr_next = '0;
            ipc_next   = '0;
            ipc1_next  = '0;
            valid_next = 1'b0;
            state_next = HALT;
        end else if (stall) begin
            if (flush) begin
                instr_next = '0;
                ipc_next   = '0;
                ipc1_next  = '0;
                valid_next = 1'b0;
            end
        end else if (flush) begin
            instr_next = '0;
            ipc_next   = '0;
            ipc1_next  = '0;
            valid_next = 1'b0;
            pc_next    = pc_inc;
        end else begin
            instr_next = imem_instr;
            ipc_next   = pc;
            ipc1_next  = pc_inc;
            valid_next = 1'b1;
            pc_next    = pc_inc;
            count_next = fetch_count + N'(1);
            if (pc_inc >= LIMIT) begin
                state_next = HALT;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a behavioural 32-word ROM.
module tb_instr_fetch_stage;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         flush;
    logic         redirect_valid;
    logic [N-1:0] redirect_target;
    logic [N-1:0] imem_addr;
    logic [N-1:0] imem_instr;
    logic [N-1:0] if_id_instr;
    logic [N-1:0] if_id_pc;
    logic [N-1:0] if_id_pc_plus1;
    logic         if_id_valid;
    logic         halted;
    logic [N-1:0] fetch_count;

    logic [N-1:0] rom [DEPTH];

    int n_checks = 0;
    int n_fails  = 0;

    instr_fetch_stage #(.N(N), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus1  (if_id_pc_plus1),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational ROM; unpopulated addresses read as X
    always_comb begin
        if (imem_addr < N'(DEPTH)) imem_instr = rom[imem_addr[4:0]];
        else                       imem_instr = 'x;
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [N-1:0] instr, input logic [N-1:0] pcv,
                          input logic valid, input logic [N-1:0] count);
        chk({tag, "_instr"}, if_id_instr, instr);
        chk({tag, "_pc"}, if_id_pc, pcv);
        chk({tag, "_valid"}, N'(if_id_valid), N'(valid));
        chk({tag, "_count"}, fetch_count, count);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = 32'hA000_0000 + N'(i);
        rom[0] = 32'h2C23_0003;
        rom[1] = 32'h2823_4002;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
        #12;
        chk_if("reset", '0, '0, 1'b0, '0);
        chk("reset_addr", imem_addr, '0);
        chk("reset_halted", N'(halted), '0);
        chk("reset_pc1", if_id_pc_plus1, '0);
        rst_n = 1'b1;

        // Free-run from address 0
        step();
        chk_if("e1", 32'h2C23_0003, 0, 1'b1, 1);
        chk("e1_pc1", if_id_pc_plus1, 1);
        step();
        chk_if("e2", 32'h2823_4002, 1, 1'b1, 2);
        chk("e2_pc1", if_id_pc_plus1, 2);
        chk("e2_addr", imem_addr, 2);

        // Stall holds PC and IF/ID
        stall = 1'b1;
        step(); step(); step();
        chk("stall_addr", imem_addr, 2);
        chk_if("stall", 32'h2823_4002, 1, 1'b1, 2);
        stall = 1'b0;
        step();
        chk_if("unstall", 32'hA000_0002, 2, 1'b1, 3);

        // Redirect beats stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 9;
        step();
        chk_if("redir", '0, '0, 1'b0, 3);
        chk("redir_addr", imem_addr, 9);
        stall = 1'b0; redirect_valid = 1'b0;
        step();
        chk_if("redir9", 32'hA000_0009, 9, 1'b1, 4);
        chk("redir9_pc1", if_id_pc_plus1, 10);

        // Run to the end of the ROM
        for (int i = 10; i <= 31; i++) step();
        chk_if("last", 32'hA000_001F, 31, 1'b1, 26);
        chk("last_halted", N'(halted), 1);
        chk("last_addr", imem_addr, 32);
        step();
        chk_if("halt", '0, '0, 1'b0, 26);
        chk("halt_addr", imem_addr, 32);
        chk("halt_halted", N'(halted), 1);
        redirect_valid = 1'b1; redirect_target = 0;
        step();
        chk("unhalt_halted", N'(halted), 0);
        chk("unhalt_addr", imem_addr, 0);
        redirect_valid = 1'b0;
        step();
        chk_if("restart", 32'h2C23_0003, 0, 1'b1, 27);

        // Flush alone advances PC; stall+flush holds PC
        flush = 1'b1;
        step();
        chk_if("flush", '0, '0, 1'b0, 27);
        chk("flush_addr", imem_addr, 2);
        flush = 1'b0;
        step();
        chk_if("postflush", 32'hA000_0002, 2, 1'b1, 28);
        stall = 1'b1; flush = 1'b1;
        step();
        chk_if("stflush", '0, '0, 1'b0, 28);
        chk("stflush_addr", imem_addr, 3);
        stall = 1'b0; flush = 1'b0;
        step();
        chk_if("poststflush", 32'hA000_0003, 3, 1'b1, 29);

        // Out-of-range redirect halts
        redirect_valid = 1'b1; redirect_target = 40;
        step();
        chk("oor_halted", N'(halted), 1);
        chk("oor_addr", imem_addr, 40);
        chk_if("oor", '0, '0, 1'b0, 29);
        redirect_valid = 1'b0;
        step();
        chk_if("oor2", '0, '0, 1'b0, 29);
        chk("oor2_halted", N'(halted), 1);

        // Recover, then async reset mid-cycle
        redirect_valid = 1'b1; redirect_target = 5;
        step();
        redirect_valid = 1'b0;
        step();
        chk_if("w5", 32'hA000_0005, 5, 1'b1, 30);
        #3;
        rst_n = 1'b0;
        #1;
        chk_if("arst", '0, '0, 1'b0, '0);
        chk("arst_addr", imem_addr, '0);
        chk("arst_pc1", if_id_pc_plus1, '0);
        #1;
        rst_n = 1'b1;
        step();
        chk_if("after_rst", 32'h2C23_0003, 0, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
